// File: rtl/writeback_buffer_pkg.sv
// Shared types and default geometry for the write-back buffer.
//   wb_state_t   : controller states (IDLE, RESP, RD_MEM, DRAIN)
//   WB_*         : default depth, line width, address width and line offset bits
package writeback_buffer_pkg;

    localparam int WB_DEPTH    = 4;
    localparam int WB_LINE_W   = 256;
    localparam int WB_ADDR_W   = 32;
    localparam int WB_OFFSET_W = 5;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RESP   = 2'd1,
        S_RD_MEM = 2'd2,
        S_DRAIN  = 2'd3
    } wb_state_t;

endpackage

// File: rtl/writeback_buffer_if.sv
// Line-granular memory bus, used both between the cache and the buffer and
// between the buffer and the cacheline adaptor.
//   address : byte address of the line
//   read    : line read request, held until resp
//   write   : line write request, held until resp
//   wdata   : write data, valid with write
//   rdata   : read data, valid with resp
//   resp    : one-cycle completion pulse
// master issues requests, slave answers them.
interface writeback_buffer_if
    import writeback_buffer_pkg::*;
#(
    parameter int ADDR_W = WB_ADDR_W,
    parameter int LINE_W = WB_LINE_W
);
    logic [ADDR_W-1:0] address;
    logic              read;
    logic              write;
    logic [LINE_W-1:0] wdata;
    logic [LINE_W-1:0] rdata;
    logic              resp;

    modport master (output address, read, write, wdata, input rdata, resp);
    modport slave  (input address, read, write, wdata, output rdata, resp);
endinterface

// File: rtl/writeback_buffer_entry_array.sv
// Line storage for the write-back buffer: a circular FIFO of DEPTH entries
// with a fully associative tag lookup.
//   lookup_tag_i               : tag compared against all valid entries
//   hit_o/hit_idx_o/hit_data_o : match flag, matching index and its data
//   push_i/push_tag_i/push_data_i : append an entry at the tail
//   pop_i                      : retire the head entry
//   write_at_i/write_idx_i/write_data_i : overwrite data of an existing entry
//   head_tag_o/head_data_o     : oldest entry, the next one to drain
//   count_o/full_o             : occupancy
module writeback_buffer_entry_array #(
    parameter int DEPTH  = 4,
    parameter int TAG_W  = 27,
    parameter int LINE_W = 256,
    localparam int IDX_W = $clog2(DEPTH),
    localparam int CNT_W = IDX_W + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [TAG_W-1:0]  lookup_tag_i,
    output logic              hit_o,
    output logic [IDX_W-1:0]  hit_idx_o,
    output logic [LINE_W-1:0] hit_data_o,
    input  logic              push_i,
    input  logic [TAG_W-1:0]  push_tag_i,
    input  logic [LINE_W-1:0] push_data_i,
    input  logic              pop_i,
    input  logic              write_at_i,
    input  logic [IDX_W-1:0]  write_idx_i,
    input  logic [LINE_W-1:0] write_data_i,
    output logic [TAG_W-1:0]  head_tag_o,
    output logic [LINE_W-1:0] head_data_o,
    output logic [CNT_W-1:0]  count_o,
    output logic              full_o
);
    logic [DEPTH-1:0]  valid_q;
    logic [TAG_W-1:0]  tag_q  [DEPTH];
    logic [LINE_W-1:0] data_q [DEPTH];
    logic [IDX_W-1:0]  head_q, tail_q;
    logic [CNT_W-1:0]  count_q;

    // DEPTH is a power of two, so the pointers wrap by plain overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (push_i) begin
                valid_q[tail_q] <= 1'b1;
                tail_q          <= tail_q + 1'b1;
            end
            if (pop_i) begin
                valid_q[head_q] <= 1'b0;
                head_q          <= head_q + 1'b1;
            end
            count_q <= count_q + CNT_W'(push_i) - CNT_W'(pop_i);
        end
    end

    // Tag and data are qualified by valid_q, so they need no reset.
    always_ff @(posedge clk) begin
        if (push_i) begin
            tag_q[tail_q]  <= push_tag_i;
            data_q[tail_q] <= push_data_i;
        end
        if (write_at_i) begin
            data_q[write_idx_i] <= write_data_i;
        end
    end

    // Coalescing keeps valid tags unique, so at most one entry matches.
    always_comb begin
        hit_o     = 1'b0;
        hit_idx_o = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && (tag_q[i] == lookup_tag_i)) begin
                hit_o     = 1'b1;
                hit_idx_o = IDX_W'(i);
            end
        end
    end

    assign hit_data_o  = data_q[hit_idx_o];
    assign head_tag_o  = tag_q[head_q];
    assign head_data_o = data_q[head_q];
    assign count_o     = count_q;
    assign full_o      = (count_q == CNT_W'(DEPTH));
endmodule

// File: rtl/writeback_buffer.sv
// Write-back buffer between the L1 pmem port and the cacheline adaptor.
// Evictions are absorbed into a small line FIFO and drained while the cache
// is idle; read misses bypass pending drains, and reads that hit a buffered
// line are served from the buffer.
//   clk, rst : clock, asynchronous active-high reset
//   cache    : slave side, requests from the L1 cache
//   pmem     : master side, requests to the cacheline adaptor
module writeback_buffer
    import writeback_buffer_pkg::*;
#(
    parameter int DEPTH    = WB_DEPTH,    // power of two, >= 2
    parameter int LINE_W   = WB_LINE_W,
    parameter int ADDR_W   = WB_ADDR_W,
    parameter int OFFSET_W = WB_OFFSET_W
) (
    input  logic               clk,
    input  logic               rst,
    writeback_buffer_if.slave  cache,
    writeback_buffer_if.master pmem
);
    localparam int TAG_W = ADDR_W - OFFSET_W;
    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = IDX_W + 1;

    wb_state_t         state_q;
    logic              cache_resp_q, pmem_read_q, pmem_write_q;
    logic [LINE_W-1:0] cache_rdata_q, pmem_wdata_q;
    logic [ADDR_W-1:0] pmem_address_q;

    logic [TAG_W-1:0]  req_tag, head_tag;
    logic              hit, full;
    logic [IDX_W-1:0]  hit_idx;
    logic [LINE_W-1:0] hit_data, head_data;
    logic [CNT_W-1:0]  count;
    logic              push, pop, write_at;
    logic              is_idle, wr_req;
    logic              unused_offset;

    assign req_tag       = cache.address[ADDR_W-1:OFFSET_W];
    assign unused_offset = ^cache.address[OFFSET_W-1:0];

    // A simultaneous read and write is treated as a read.
    assign is_idle  = (state_q == S_IDLE);
    assign wr_req   = cache.write && !cache.read;
    assign write_at = is_idle && wr_req && hit;
    assign push     = is_idle && wr_req && !hit && !full;
    assign pop      = (state_q == S_DRAIN) && pmem.resp;

    writeback_buffer_entry_array #(
        .DEPTH (DEPTH),
        .TAG_W (TAG_W),
        .LINE_W(LINE_W)
    ) u_array (
        .clk         (clk),
        .rst         (rst),
        .lookup_tag_i(req_tag),
        .hit_o       (hit),
        .hit_idx_o   (hit_idx),
        .hit_data_o  (hit_data),
        .push_i      (push),
        .push_tag_i  (req_tag),
        .push_data_i (cache.wdata),
        .pop_i       (pop),
        .write_at_i  (write_at),
        .write_idx_i (hit_idx),
        .write_data_i(cache.wdata),
        .head_tag_o  (head_tag),
        .head_data_o (head_data),
        .count_o     (count),
        .full_o      (full)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= S_IDLE;
            cache_resp_q   <= 1'b0;
            cache_rdata_q  <= '0;
            pmem_read_q    <= 1'b0;
            pmem_write_q   <= 1'b0;
            pmem_address_q <= '0;
            pmem_wdata_q   <= '0;
        end else begin
            cache_resp_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (cache.read) begin
                        if (hit) begin
                            cache_rdata_q <= hit_data;
                            cache_resp_q  <= 1'b1;
                            state_q       <= S_RESP;
                        end else begin
                            pmem_read_q    <= 1'b1;
                            pmem_address_q <= {req_tag, {OFFSET_W{1'b0}}};
                            state_q        <= S_RD_MEM;
                        end
                    end else if (cache.write && (hit || !full)) begin
                        cache_resp_q <= 1'b1;
                        state_q      <= S_RESP;
                    end else if (count != '0) begin
                        // Idle drain, or making room for a write miss on a full buffer.
                        pmem_write_q   <= 1'b1;
                        pmem_address_q <= {head_tag, {OFFSET_W{1'b0}}};
                        pmem_wdata_q   <= head_data;
                        state_q        <= S_DRAIN;
                    end
                end
                S_RESP: state_q <= S_IDLE;
                S_RD_MEM: begin
                    if (pmem.resp) begin
                        pmem_read_q   <= 1'b0;
                        cache_rdata_q <= pmem.rdata;
                        cache_resp_q  <= 1'b1;
                        state_q       <= S_RESP;
                    end
                end
                S_DRAIN: begin
                    if (pmem.resp) begin
                        pmem_write_q <= 1'b0;
                        state_q      <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign cache.resp   = cache_resp_q;
    assign cache.rdata  = cache_rdata_q;
    assign pmem.address = pmem_address_q;
    assign pmem.read    = pmem_read_q;
    assign pmem.write   = pmem_write_q;
    assign pmem.wdata   = pmem_wdata_q;

    a_no_rd_wr_cache: assert property (@(posedge clk) disable iff (rst)
        !(cache.read && cache.write));
    a_no_rd_wr_pmem: assert property (@(posedge clk) disable iff (rst)
        !(pmem.read && pmem.write));
endmodule
